// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host scan code receiver.
// Conditions the asynchronous PS2_CLK/PS2_DATA pins, deframes 11-bit frames
// (start, 8 data LSB-first, odd parity, stop) and folds E0/F0 prefixes into a
// single 16-bit key word held on o_ps2_data until the next key arrives.
module ps2_scan_rx #(
    parameter int unsigned FILT_LEN    = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic        CLK_50M,
    input  logic        RST_N,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    output logic [15:0] o_ps2_data,
    output logic        o_ext,
    output logic        o_valid,
    output logic        o_frame_err
);

    localparam int unsigned FCW = $clog2(FILT_LEN + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning signals
    // ------------------------------------------------------------------
    logic           clk_s1_q, clk_s2_q;
    logic           dat_s1_q, dat_s2_q;
    logic           clk_filt_q, clk_filt_d;
    logic           dat_filt_q, dat_filt_d;
    logic [FCW-1:0] clk_fcnt_q, clk_fcnt_d;
    logic [FCW-1:0] dat_fcnt_q, dat_fcnt_d;
    logic           clk_prev_q;
    logic           fall;

    // ------------------------------------------------------------------
    // Frame FSM signals
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic           par_q, par_d;
    logic [TCW-1:0] to_cnt_q, to_cnt_d;
    logic           timeout;
    logic           byte_done_q, byte_done_d;
    logic           frame_err_q, frame_err_d;

    // ------------------------------------------------------------------
    // Decoder signals
    // ------------------------------------------------------------------
    logic           ext_q, ext_d;
    logic           brk_q, brk_d;
    logic [15:0]    key_q, key_d;
    logic           key_ext_q, key_ext_d;
    logic           valid_q, valid_d;

    // Two-flop synchronisers, preset to the idle-high bus level.
    always_ff @(posedge CLK_50M) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours, regardless of order.
        if (!RST_N) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= PS2_CLK;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= PS2_DATA;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Glitch filters: flip only after FILT_LEN consecutive opposite samples.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        clk_filt_d = clk_filt_q;
        clk_fcnt_d = '0;
        dat_filt_d = dat_filt_q;
        dat_fcnt_d = '0;
        if (clk_s2_q != clk_filt_q) begin
            if (clk_fcnt_q == FCW'(FILT_LEN - 1)) begin
                clk_filt_d = clk_s2_q;
            end else begin
                clk_fcnt_d = clk_fcnt_q + 1'b1;
            end
        end
        if (dat_s2_q != dat_filt_q) begin
            if (dat_fcnt_q == FCW'(FILT_LEN - 1)) begin
                dat_filt_d = dat_s2_q;
            end else begin
                dat_fcnt_d = dat_fcnt_q + 1'b1;
            end
        end
    end

    // Filter state and previous filtered clock for edge detection.
    always_ff @(posedge CLK_50M) begin
        if (!RST_N) begin
            clk_filt_q <= 1'b1;
            dat_filt_q <= 1'b1;
            clk_fcnt_q <= '0;
            dat_fcnt_q <= '0;
            clk_prev_q <= 1'b1;
        end else begin
            clk_filt_q <= clk_filt_d;
            dat_filt_q <= dat_filt_d;
            clk_fcnt_q <= clk_fcnt_d;
            dat_fcnt_q <= dat_fcnt_d;
            clk_prev_q <= clk_filt_q;
        end
    end

    // Single-cycle strobe on a filtered PS2_CLK falling edge.
    assign fall = clk_prev_q & ~clk_filt_q;

    // Mid-frame watchdog expiry; takes priority over a coincident fall.
    assign timeout = (state_q != S_IDLE) && (to_cnt_q >= TCW'(TIMEOUT_CYC - 1));

    // Frame FSM state register.
    always_ff @(posedge CLK_50M) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame FSM next-state logic: advances on fall, or drops to IDLE on timeout.
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = S_IDLE;
        end else if (fall) begin
            case (state_q)
                S_IDLE:   if (!dat_filt_q) state_d = S_DATA;
                S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                S_PARITY: state_d = S_STOP;
                S_STOP:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Frame FSM outputs and datapath: shift register, parity, checks, watchdog.
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        par_d       = par_q;
        byte_done_d = 1'b0;
        frame_err_d = 1'b0;

        if (state_q == S_IDLE || fall || timeout) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        if (timeout) begin
            frame_err_d = 1'b1;
        end else if (fall) begin
            case (state_q)
                S_IDLE: begin
                    bit_cnt_d = 3'd0;
                end
                S_DATA: begin
                    shift_d   = {dat_filt_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                S_PARITY: begin
                    par_d = dat_filt_q;
                end
                S_STOP: begin
                    // Good frame: stop bit high and odd parity across data+parity.
                    if (dat_filt_q && (^{par_q, shift_q})) begin
                        byte_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame datapath registers and completion/error strobes.
    always_ff @(posedge CLK_50M) begin
        if (!RST_N) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            byte_done_q <= byte_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Decoder: fold E0/F0 prefixes, publish the key word on a non-prefix byte.
    always_comb begin
        ext_d     = ext_q;
        brk_d     = brk_q;
        key_d     = key_q;
        key_ext_d = key_ext_q;
        valid_d   = 1'b0;
        if (frame_err_q) begin
            // A broken frame invalidates any pending prefix.
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_done_q) begin
            case (shift_q)
                CODE_EXT: ext_d = 1'b1;
                CODE_BRK: brk_d = 1'b1;
                default: begin
                    key_d     = {(brk_q ? CODE_BRK : 8'h00), shift_q};
                    key_ext_d = ext_q;
                    valid_d   = 1'b1;
                    ext_d     = 1'b0;
                    brk_d     = 1'b0;
                end
            endcase
        end
    end

    // Decoder registers.
    always_ff @(posedge CLK_50M) begin
        if (!RST_N) begin
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            key_q     <= '0;
            key_ext_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            key_q     <= key_d;
            key_ext_q <= key_ext_d;
            valid_q   <= valid_d;
        end
    end

    assign o_ps2_data  = key_q;
    assign o_ext       = key_ext_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Scoreboard bench for ps2_scan_rx: the stimulus process pushes hand-computed
// expected events, an independent monitor pops and compares on each
// o_valid / o_frame_err pulse. Timing is scaled down (short bit period and
// timeout) so the whole run stays small.
module tb_ps2_scan_rx;

    localparam int HALF    = 40;    // half PS/2 bit period in system cycles
    localparam int TIMEOUT = 1000;  // scaled-down mid-frame timeout

    logic        clk_50m = 1'b0;
    logic        rst_n   = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] o_ps2_data;
    logic        o_ext;
    logic        o_valid;
    logic        o_frame_err;

    typedef struct {
        bit          is_err;
        logic [15:0] data;
        logic        ext;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    ps2_scan_rx #(
        .FILT_LEN   (8),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .CLK_50M    (clk_50m),
        .RST_N      (rst_n),
        .PS2_CLK    (ps2_clk),
        .PS2_DATA   (ps2_data),
        .o_ps2_data (o_ps2_data),
        .o_ext      (o_ext),
        .o_valid    (o_valid),
        .o_frame_err(o_frame_err)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_50m);
        #1;
    endtask

    task automatic expect_valid(input logic [15:0] data, input logic ext);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = data;
        e.ext    = ext;
        exp_q.push_back(e);
    endtask

    // Error pulse expected; data/ext must still hold the previous key.
    task automatic expect_err(input logic [15:0] held, input logic held_ext);
        exp_t e;
        e.is_err = 1'b1;
        e.data   = held;
        e.ext    = held_ext;
        exp_q.push_back(e);
    endtask

    // Drive the first nbits bits of a frame; bad flips the parity bit.
    task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
    endtask

    // Monitor: compare every output event against the head of the queue.
    always @(negedge clk_50m) begin
        if (rst_n && (o_valid || o_frame_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {30'd0, o_valid, o_frame_err}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_err",   {31'd0, o_frame_err}, {31'd0, e.is_err});
                check("event_valid", {31'd0, o_valid},     {31'd0, !e.is_err});
                check("ps2_data",    {16'd0, o_ps2_data},  {16'd0, e.data});
                check("ext",         {31'd0, o_ext},       {31'd0, e.ext});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        wait_cyc(3);
        @(negedge clk_50m);
        check("rst_data",  {16'd0, o_ps2_data}, 32'd0);
        check("rst_ext",   {31'd0, o_ext},      32'd0);
        check("rst_valid", {31'd0, o_valid},    32'd0);
        check("rst_err",   {31'd0, o_frame_err}, 32'd0);
        wait_cyc(1);
        rst_n = 1'b1;
        wait_cyc(20);

        // Plain make code
        expect_valid(16'h001C, 1'b0);
        send_byte(8'h1C);

        // Break: F0 gives nothing, 1C gives F01C
        send_byte(8'hF0);
        expect_valid(16'hF01C, 1'b0);
        send_byte(8'h1C);

        // Extended make, then extended break
        send_byte(8'hE0);
        expect_valid(16'h0075, 1'b1);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        expect_valid(16'hF075, 1'b1);
        send_byte(8'h75);

        // F0 then bad parity: error, data held, prefix cleared
        send_byte(8'hF0);
        expect_err(16'hF075, 1'b1);
        send_frame(8'h1C, 1'b1, 11);
        expect_valid(16'h001C, 1'b0);
        send_byte(8'h1C);

        // Typematic repeat of the same make code
        expect_valid(16'h001C, 1'b0);
        send_byte(8'h1C);

        // Short low glitch on PS2_CLK in IDLE: filtered out entirely
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(4 * HALF);

        // Truncated frame (start + 4 data bits) then silence -> timeout
        expect_err(16'h001C, 1'b0);
        send_frame(8'h29, 1'b0, 5);
        wait_cyc(TIMEOUT + 200);
        expect_valid(16'h0029, 1'b0);
        send_byte(8'h29);

        // Reset mid-frame: outputs clear, partial frame discarded
        send_frame(8'h75, 1'b0, 4);
        rst_n = 1'b0;
        wait_cyc(2);
        @(negedge clk_50m);
        check("midrst_data",  {16'd0, o_ps2_data}, 32'd0);
        check("midrst_ext",   {31'd0, o_ext},      32'd0);
        check("midrst_valid", {31'd0, o_valid},    32'd0);
        wait_cyc(1);
        rst_n = 1'b1;
        wait_cyc(20);
        expect_valid(16'h001C, 1'b0);
        send_byte(8'h1C);

        // Drain: every expected event must have been seen
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            wait_cyc(1);
        end
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
